// File: rtl/clint_vec.sv
// Core-local trap controller: arbitrates exceptions, interrupts and mret,
// sequences the trap CSR writes and redirects fetch to the trap target.
module clint_vec #(
  parameter int unsigned      XLEN        = 64,
  parameter int unsigned      N_IRQ       = 12,
  parameter logic [N_IRQ-1:0] IRQ_MASK    = N_IRQ'(12'h888),
  parameter bit               VECTORED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic [3:0]       i_expt_info,
  input  logic [XLEN-1:0]  i_instr_addr,
  input  logic [31:0]      i_instr,
  input  logic             i_branch_jump,
  input  logic [XLEN-1:0]  i_jump_addr,
  input  logic [XLEN-1:0]  i_csr_mstatus,
  input  logic [XLEN-1:0]  i_csr_mie,
  input  logic [XLEN-1:0]  i_csr_mtvec,
  input  logic [XLEN-1:0]  i_csr_mepc,
  input  logic             i_int_ready,
  output logic             o_int_valid,
  output logic [XLEN-1:0]  o_int_addr,
  output logic             o_hold,
  output logic             o_csr_wen,
  output logic [11:0]      o_csr_waddr,
  output logic [XLEN-1:0]  o_csr_wdata
);

  localparam int unsigned IdxW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  typedef enum logic [2:0] {
    StIdle, StMepc, StMcause, StMtval, StMstatus, StMret, StJump
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;

  logic             ecall, ebreak, illegal, mret;
  logic [N_IRQ-1:0] irq_vec;
  logic             irq_req;
  logic [IdxW-1:0]  irq_idx;
  logic             trap_req;
  logic             sel_irq, sel_mret;
  logic [XLEN-1:0]  sel_cause, sel_tval, sel_epc;
  logic [XLEN-1:0]  mtvec_base, vec_off, trap_target;
  logic [XLEN-1:0]  ms_trap, ms_mret;

  // Upper mie bits have no interrupt line behind them.
  logic unused_mie;
  assign unused_mie = ^i_csr_mie[XLEN-1:N_IRQ];

  assign {ecall, ebreak, illegal, mret} = i_expt_info;

  assign irq_vec = i_irq & i_csr_mie[N_IRQ-1:0] & IRQ_MASK;
  assign irq_req = i_csr_mstatus[3] & (|irq_vec);

  // Highest pending enabled line wins: later iterations overwrite earlier ones.
  always_comb begin
    irq_idx = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (irq_vec[i]) irq_idx = IdxW'(i);
    end
  end

  // Fixed-priority request select: ecall > ebreak > illegal > interrupt > mret.
  always_comb begin
    trap_req  = 1'b1;
    sel_irq   = 1'b0;
    sel_mret  = 1'b0;
    sel_cause = '0;
    sel_tval  = '0;
    if (ecall) begin
      sel_cause = XLEN'(11);
    end else if (ebreak) begin
      sel_cause = XLEN'(3);
      sel_tval  = i_instr_addr;
    end else if (illegal) begin
      sel_cause = XLEN'(2);
      sel_tval  = XLEN'(i_instr);
    end else if (irq_req) begin
      sel_irq   = 1'b1;
      sel_cause = {1'b1, (XLEN-1)'(irq_idx)};
    end else if (mret) begin
      sel_mret  = 1'b1;
    end else begin
      trap_req  = 1'b0;
    end
  end

  // An interrupt taken on a branch resumes at the branch target, not the branch itself.
  assign sel_epc = (sel_irq && i_branch_jump) ? i_jump_addr : i_instr_addr;

  // Trap vector: vectored offset only for interrupts with mtvec.MODE == 1.
  always_comb begin
    mtvec_base  = {i_csr_mtvec[XLEN-1:2], 2'b00};
    vec_off     = XLEN'(irq_idx) << 2;
    trap_target = mtvec_base;
    if (VECTORED_EN && sel_irq && (i_csr_mtvec[1:0] == 2'b01)) begin
      trap_target = mtvec_base + vec_off;
    end
  end

  // mstatus images for trap entry and mret.
  always_comb begin
    ms_trap        = i_csr_mstatus;
    ms_trap[7]     = i_csr_mstatus[3];
    ms_trap[3]     = 1'b0;
    ms_trap[12:11] = 2'b11;
    ms_mret        = i_csr_mstatus;
    ms_mret[3]     = i_csr_mstatus[7];
    ms_mret[7]     = 1'b1;
    ms_mret[12:11] = 2'b11;
  end

  // Next-state logic for the write sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (trap_req) state_d = sel_mret ? StMret : StMepc;
      end
      StMepc:    state_d = StMcause;
      StMcause:  state_d = StMtval;
      StMtval:   state_d = StMstatus;
      StMstatus: state_d = StJump;
      StMret:    state_d = StJump;
      StJump: begin
        if (i_int_ready) state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Trap context is captured once on leaving IDLE; mret target is taken in MRET.
  always_comb begin
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    target_d = target_q;
    if (state_q == StIdle && trap_req) begin
      cause_d  = sel_cause;
      epc_d    = sel_epc;
      tval_d   = sel_tval;
      target_d = trap_target;
    end else if (state_q == StMret) begin
      target_d = i_csr_mepc;
    end
  end

  // State and context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

  // Moore-decoded CSR write port and redirect request.
  always_comb begin
    o_csr_wen   = 1'b0;
    o_csr_waddr = '0;
    o_csr_wdata = '0;
    o_int_valid = 1'b0;
    o_int_addr  = '0;
    unique case (state_q)
      StMepc: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CsrMepc;
        o_csr_wdata = epc_q;
      end
      StMcause: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CsrMcause;
        o_csr_wdata = cause_q;
      end
      StMtval: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CsrMtval;
        o_csr_wdata = tval_q;
      end
      StMstatus: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CsrMstatus;
        o_csr_wdata = ms_trap;
      end
      StMret: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CsrMstatus;
        o_csr_wdata = ms_mret;
      end
      StJump: begin
        o_int_valid = 1'b1;
        o_int_addr  = target_q;
      end
      default: ;
    endcase
  end

  // Stall the front end as soon as a request is seen and until the redirect is taken.
  assign o_hold = trap_req | (state_q != StIdle);

endmodule

// File: tb/tb_clint_vec.sv
// Directed self-checking bench for clint_vec.
module tb_clint_vec;

  localparam int XLEN  = 64;
  localparam int N_IRQ = 12;

  logic             clk;
  logic             rst;
  logic [N_IRQ-1:0] i_irq;
  logic [3:0]       i_expt_info;
  logic [XLEN-1:0]  i_instr_addr;
  logic [31:0]      i_instr;
  logic             i_branch_jump;
  logic [XLEN-1:0]  i_jump_addr;
  logic [XLEN-1:0]  i_csr_mstatus;
  logic [XLEN-1:0]  i_csr_mie;
  logic [XLEN-1:0]  i_csr_mtvec;
  logic [XLEN-1:0]  i_csr_mepc;
  logic             i_int_ready;
  logic             o_int_valid;
  logic [XLEN-1:0]  o_int_addr;
  logic             o_hold;
  logic             o_csr_wen;
  logic [11:0]      o_csr_waddr;
  logic [XLEN-1:0]  o_csr_wdata;

  int errors = 0;
  int checks = 0;

  clint_vec #(
    .XLEN       (XLEN),
    .N_IRQ      (N_IRQ),
    .IRQ_MASK   (12'h888),
    .VECTORED_EN(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_irq        (i_irq),
    .i_expt_info  (i_expt_info),
    .i_instr_addr (i_instr_addr),
    .i_instr      (i_instr),
    .i_branch_jump(i_branch_jump),
    .i_jump_addr  (i_jump_addr),
    .i_csr_mstatus(i_csr_mstatus),
    .i_csr_mie    (i_csr_mie),
    .i_csr_mtvec  (i_csr_mtvec),
    .i_csr_mepc   (i_csr_mepc),
    .i_int_ready  (i_int_ready),
    .o_int_valid  (o_int_valid),
    .o_int_addr   (o_int_addr),
    .o_hold       (o_hold),
    .o_csr_wen    (o_csr_wen),
    .o_csr_waddr  (o_csr_waddr),
    .o_csr_wdata  (o_csr_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output bundle: {wen, waddr, wdata, valid, addr, hold}.
  typedef logic [142:0] obs_t;
  obs_t obs;
  assign obs = {o_csr_wen, o_csr_waddr, o_csr_wdata, o_int_valid, o_int_addr, o_hold};

  function automatic obs_t pk(input logic wen, input logic [11:0] a, input logic [63:0] d,
                              input logic v, input logic [63:0] ia, input logic h);
    return {wen, a, d, v, ia, h};
  endfunction

  task automatic clear_inputs();
    i_irq         = '0;
    i_expt_info   = '0;
    i_instr_addr  = '0;
    i_instr       = '0;
    i_branch_jump = 1'b0;
    i_jump_addr   = '0;
    i_csr_mstatus = '0;
    i_csr_mie     = '0;
    i_csr_mtvec   = '0;
    i_csr_mepc    = '0;
    i_int_ready   = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_held obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    step();
  endtask

  task automatic test_ecall();
    obs_t e[5];
    e[0] = pk(1, 12'h341, 64'h8000_0010, 0, 0, 1);
    e[1] = pk(1, 12'h342, 64'd11, 0, 0, 1);
    e[2] = pk(1, 12'h343, 64'd0, 0, 0, 1);
    e[3] = pk(1, 12'h300, 64'h1880, 0, 0, 1);
    e[4] = pk(0, 0, 0, 1, 64'h8000_1000, 1);
    clear_inputs();
    i_csr_mstatus = 64'h8;
    i_csr_mtvec   = 64'h8000_1000;
    i_instr_addr  = 64'h8000_0010;
    i_expt_info   = 4'b1000;
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL ecall_c0_hold obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 1));
    end
    step();
    i_expt_info = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL ecall_c%0d obs=%h exp=%h", i + 1, obs, e[i]);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL ecall_idle obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    step();
  endtask

  task automatic test_irq_vectored();
    obs_t e[5];
    e[0] = pk(1, 12'h341, 64'h8000_0200, 0, 0, 1);
    e[1] = pk(1, 12'h342, 64'h8000_0000_0000_0007, 0, 0, 1);
    e[2] = pk(1, 12'h343, 64'd0, 0, 0, 1);
    e[3] = pk(1, 12'h300, 64'h1880, 0, 0, 1);
    e[4] = pk(0, 0, 0, 1, 64'h8000_101C, 1);
    clear_inputs();
    i_csr_mstatus = 64'h8;
    i_csr_mie     = 64'h80;
    i_csr_mtvec   = 64'h8000_1001;
    i_instr_addr  = 64'h8000_0100;
    i_branch_jump = 1'b1;
    i_jump_addr   = 64'h8000_0200;
    i_irq         = 12'h080;
    step();
    i_irq         = '0;
    i_branch_jump = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL irq7_c%0d obs=%h exp=%h", i + 1, obs, e[i]);
      end
      step();
    end
  endtask

  task automatic test_irq_priority();
    obs_t e[5];
    e[0] = pk(1, 12'h341, 64'h8000_0060, 0, 0, 1);
    e[1] = pk(1, 12'h342, 64'h8000_0000_0000_000B, 0, 0, 1);
    e[2] = pk(1, 12'h343, 64'd0, 0, 0, 1);
    e[3] = pk(1, 12'h300, 64'h1880, 0, 0, 1);
    e[4] = pk(0, 0, 0, 1, 64'h8000_102C, 1);
    clear_inputs();
    i_csr_mstatus = 64'h8;
    i_csr_mie     = 64'h880;
    i_csr_mtvec   = 64'h8000_1001;
    i_instr_addr  = 64'h8000_0060;
    i_irq         = 12'h880;
    step();
    i_irq = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL irq11_c%0d obs=%h exp=%h", i + 1, obs, e[i]);
      end
      step();
    end
  endtask

  // ecall beats a pending interrupt; exception ignores vectored mode and branch target.
  task automatic test_ecall_over_irq();
    obs_t e[5];
    e[0] = pk(1, 12'h341, 64'h8000_0050, 0, 0, 1);
    e[1] = pk(1, 12'h342, 64'd11, 0, 0, 1);
    e[2] = pk(1, 12'h343, 64'd0, 0, 0, 1);
    e[3] = pk(1, 12'h300, 64'h1880, 0, 0, 1);
    e[4] = pk(0, 0, 0, 1, 64'h8000_1000, 1);
    clear_inputs();
    i_csr_mstatus = 64'h8;
    i_csr_mie     = 64'h880;
    i_csr_mtvec   = 64'h8000_1001;
    i_instr_addr  = 64'h8000_0050;
    i_branch_jump = 1'b1;
    i_jump_addr   = 64'h8000_0300;
    i_irq         = 12'h880;
    i_expt_info   = 4'b1000;
    step();
    i_irq       = '0;
    i_expt_info = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL ecall_irq_c%0d obs=%h exp=%h", i + 1, obs, e[i]);
      end
      step();
    end
  endtask

  task automatic test_exceptions();
    obs_t eb[5];
    obs_t il[5];
    eb[0] = pk(1, 12'h341, 64'h8000_0020, 0, 0, 1);
    eb[1] = pk(1, 12'h342, 64'd3, 0, 0, 1);
    eb[2] = pk(1, 12'h343, 64'h8000_0020, 0, 0, 1);
    eb[3] = pk(1, 12'h300, 64'h1800, 0, 0, 1);
    eb[4] = pk(0, 0, 0, 1, 64'h8000_1000, 1);
    il[0] = pk(1, 12'h341, 64'h8000_0030, 0, 0, 1);
    il[1] = pk(1, 12'h342, 64'd2, 0, 0, 1);
    il[2] = pk(1, 12'h343, 64'h0000_0000_FFFF_FFFF, 0, 0, 1);
    il[3] = pk(1, 12'h300, 64'h1880, 0, 0, 1);
    il[4] = pk(0, 0, 0, 1, 64'h8000_1000, 1);
    clear_inputs();
    i_csr_mtvec  = 64'h8000_1001;
    i_instr_addr = 64'h8000_0020;
    i_expt_info  = 4'b0100;
    step();
    i_expt_info = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== eb[i]) begin
        errors++;
        $display("FAIL ebreak_c%0d obs=%h exp=%h", i + 1, obs, eb[i]);
      end
      step();
    end
    i_csr_mstatus = 64'h88;
    i_instr_addr  = 64'h8000_0030;
    i_instr       = 32'hFFFF_FFFF;
    i_expt_info   = 4'b0010;
    step();
    i_expt_info = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== il[i]) begin
        errors++;
        $display("FAIL illegal_c%0d obs=%h exp=%h", i + 1, obs, il[i]);
      end
      step();
    end
  endtask

  task automatic test_mret();
    clear_inputs();
    i_csr_mstatus = 64'h80;
    i_csr_mepc    = 64'h8000_0040;
    i_expt_info   = 4'b0001;
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL mret_c0_hold obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 1));
    end
    step();
    i_expt_info = '0;
    @(negedge clk);
    checks++;
    if (obs !== pk(1, 12'h300, 64'h1888, 0, 0, 1)) begin
      errors++;
      $display("FAIL mret_c1 obs=%h exp=%h", obs, pk(1, 12'h300, 64'h1888, 0, 0, 1));
    end
    step();
    i_csr_mepc = 64'h1234_5678;
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 1, 64'h8000_0040, 1)) begin
      errors++;
      $display("FAIL mret_c2 obs=%h exp=%h", obs, pk(0, 0, 0, 1, 64'h8000_0040, 1));
    end
    step();
  endtask

  task automatic test_masking();
    clear_inputs();
    i_csr_mstatus = 64'h8;
    i_csr_mie     = '1;
    i_irq         = 12'h777;
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mask_unimpl obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    i_csr_mstatus = '0;
    i_irq         = 12'h888;
    #1;
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mask_mie obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    i_csr_mstatus = 64'h8;
    i_csr_mie     = '0;
    #1;
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mask_mie_reg obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    step();
    clear_inputs();
  endtask

  task automatic test_back_to_back_stall();
    clear_inputs();
    i_csr_mstatus = 64'h8;
    i_csr_mtvec   = 64'h8000_1000;
    i_instr_addr  = 64'h8000_0070;
    i_int_ready   = 1'b0;
    i_expt_info   = 4'b1000;
    step();
    i_expt_info = '0;
    for (int i = 0; i < 4; i++) step();
    // New requests and a changed mtvec during JUMP must not disturb the redirect.
    i_expt_info = 4'b1000;
    i_csr_mtvec = 64'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== pk(0, 0, 0, 1, 64'h8000_1000, 1)) begin
        errors++;
        $display("FAIL stall_c%0d obs=%h exp=%h", i, obs, pk(0, 0, 0, 1, 64'h8000_1000, 1));
      end
      step();
    end
    i_expt_info = '0;
    i_int_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 1, 64'h8000_1000, 1)) begin
      errors++;
      $display("FAIL stall_ready obs=%h exp=%h", obs, pk(0, 0, 0, 1, 64'h8000_1000, 1));
    end
    step();
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL stall_idle obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    step();
  endtask

  task automatic test_reset_mid_sequence();
    clear_inputs();
    i_csr_mstatus = 64'h8;
    i_csr_mtvec   = 64'h8000_1000;
    i_instr_addr  = 64'h8000_0080;
    i_expt_info   = 4'b1000;
    step();
    i_expt_info = '0;
    step();
    @(negedge clk);
    checks++;
    if (obs !== pk(1, 12'h342, 64'd11, 0, 0, 1)) begin
      errors++;
      $display("FAIL rst_pre_mcause obs=%h exp=%h", obs, pk(1, 12'h342, 64'd11, 0, 0, 1));
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL rst_async obs=%h exp=%h", obs, pk(0, 0, 0, 0, 0, 0));
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL rst_no_resume_c%0d obs=%h exp=%h", i, obs, pk(0, 0, 0, 0, 0, 0));
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ecall();
    test_irq_vectored();
    test_irq_priority();
    test_ecall_over_irq();
    test_exceptions();
    test_mret();
    test_masking();
    test_back_to_back_stall();
    test_reset_mid_sequence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
